mips_control_unit: RTL and testbench

- Main decoder of a single-cycle-style MIPS datapath: maps the 6-bit instruction opcode to datapath control strobes and a 3-bit ALU operation class.
- Decode is combinational; all outputs are registered, giving one cycle of latency. The ALU control block consumes ALUOp together with the funct field.
- Sits between instruction fetch/decode and the register file, ALU, data memory and PC-select logic.

---
 rtl/mips_ctrl_pkg.sv | 33 +++
 rtl/mips_control_unit_if.sv | 37 +++
 rtl/mips_ctrl_decode.sv | 72 +++++++
 rtl/mips_control_unit.sv | 57 +++++
 tb/tb_mips_control_unit.sv | 138 +++++++++++++
 5 files changed

// File: rtl/mips_ctrl_pkg.sv
// Shared opcode and ALUOp constants plus the packed control bundle for the MIPS main decoder.
package mips_ctrl_pkg;

  // Opcodes, instruction bits [31:26]
  localparam logic [5:0] OP_RTYPE = 6'b000000;
  localparam logic [5:0] OP_ANDI  = 6'b001100;
  localparam logic [5:0] OP_ORI   = 6'b001101;
  localparam logic [5:0] OP_ADDIU = 6'b001001;
  localparam logic [5:0] OP_LW    = 6'b100011;
  localparam logic [5:0] OP_SW    = 6'b101011;
  localparam logic [5:0] OP_BEQ   = 6'b000100;
  localparam logic [5:0] OP_J     = 6'b000010;

  // ALU operation classes; 101..111 are never produced
  localparam logic [2:0] ALUOP_ADD   = 3'b000;
  localparam logic [2:0] ALUOP_SUB   = 3'b001;
  localparam logic [2:0] ALUOP_RTYPE = 3'b010;
  localparam logic [2:0] ALUOP_AND   = 3'b011;
  localparam logic [2:0] ALUOP_OR    = 3'b100;

  typedef struct packed {
    logic       reg_dst;
    logic       alu_src;
    logic       mem_to_reg;
    logic       reg_write;
    logic       mem_read;
    logic       mem_write;
    logic       branch;
    logic       jump;
    logic [2:0] alu_op;
  } ctrl_t;

endpackage

// File: rtl/mips_control_unit_if.sv
// Opcode-in / control-strobes-out bundle of the MIPS main decoder.
// ILLEGAL_OPCODE_FLAG_EN adds the IllegalOp flag.
interface mips_control_unit_if;

  logic [5:0] Opcode;
  logic       RegDst;
  logic       ALUSrc;
  logic       MemtoReg;
  logic       RegWrite;
  logic       MemRead;
  logic       MemWrite;
  logic       Branch;
  logic       Jump;
  logic [2:0] ALUOp;
`ifdef ILLEGAL_OPCODE_FLAG_EN
  logic       IllegalOp;
`endif

  // Decode stage side: supplies the opcode, consumes the strobes
  modport master (
    output Opcode,
    input  RegDst, ALUSrc, MemtoReg, RegWrite, MemRead, MemWrite, Branch, Jump, ALUOp
`ifdef ILLEGAL_OPCODE_FLAG_EN
    , input IllegalOp
`endif
  );

  // Control unit side
  modport slave (
    input  Opcode,
    output RegDst, ALUSrc, MemtoReg, RegWrite, MemRead, MemWrite, Branch, Jump, ALUOp
`ifdef ILLEGAL_OPCODE_FLAG_EN
    , output IllegalOp
`endif
  );

endinterface

// File: rtl/mips_ctrl_decode.sv
// Purely combinational opcode-to-control-bundle decoder.
// Unlisted opcodes decode to an all-zero safe NOP.
// ILLEGAL_OPCODE_FLAG_EN adds the illegal output.
module mips_ctrl_decode
  import mips_ctrl_pkg::*;
(
  input  logic [5:0] opcode,
`ifdef ILLEGAL_OPCODE_FLAG_EN
  output logic       illegal,
`endif
  output ctrl_t      ctrl
);

  logic illegal_d;

  // Table lookup, all-zero default first
  always_comb begin
    ctrl      = '0;
    illegal_d = 1'b0;
    case (opcode)
      OP_RTYPE: begin
        ctrl.reg_dst   = 1'b1;
        ctrl.reg_write = 1'b1;
        ctrl.alu_op    = ALUOP_RTYPE;
      end
      OP_ANDI: begin
        ctrl.alu_src   = 1'b1;
        ctrl.reg_write = 1'b1;
        ctrl.alu_op    = ALUOP_AND;
      end
      OP_ORI: begin
        ctrl.alu_src   = 1'b1;
        ctrl.reg_write = 1'b1;
        ctrl.alu_op    = ALUOP_OR;
      end
      OP_ADDIU: begin
        ctrl.alu_src   = 1'b1;
        ctrl.reg_write = 1'b1;
        ctrl.alu_op    = ALUOP_ADD;
      end
      OP_LW: begin
        ctrl.alu_src    = 1'b1;
        ctrl.mem_to_reg = 1'b1;
        ctrl.reg_write  = 1'b1;
        ctrl.mem_read   = 1'b1;
        ctrl.alu_op     = ALUOP_ADD;
      end
      OP_SW: begin
        ctrl.alu_src   = 1'b1;
        ctrl.mem_write = 1'b1;
        ctrl.alu_op    = ALUOP_ADD;
      end
      OP_BEQ: begin
        ctrl.branch = 1'b1;
        ctrl.alu_op = ALUOP_SUB;
      end
      OP_J: begin
        ctrl.jump = 1'b1;
      end
      default: illegal_d = 1'b1;
    endcase
  end

`ifdef ILLEGAL_OPCODE_FLAG_EN
  assign illegal = illegal_d;
`else
  // Flag not exported; keep the net consumed
  logic unused_illegal;
  assign unused_illegal = illegal_d;
`endif

endmodule

// File: rtl/mips_control_unit.sv
// MIPS main control unit: combinational decode followed by one output register stage
// with asynchronous active-high reset. ILLEGAL_OPCODE_FLAG_EN adds a registered IllegalOp.
module mips_control_unit
  import mips_ctrl_pkg::*;
(
  input logic                 clk,
  input logic                 rst,
  mips_control_unit_if.slave  bus
);

  ctrl_t ctrl_d, ctrl_q;

`ifdef ILLEGAL_OPCODE_FLAG_EN
  logic illegal_d, illegal_q;
`endif

  mips_ctrl_decode u_decode (
    .opcode  (bus.Opcode),
`ifdef ILLEGAL_OPCODE_FLAG_EN
    .illegal (illegal_d),
`endif
    .ctrl    (ctrl_d)
  );

  // Output register: clears immediately on reset, otherwise loads this cycle's decode
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      ctrl_q <= '0;
    end else begin
      ctrl_q <= ctrl_d;
    end
  end

`ifdef ILLEGAL_OPCODE_FLAG_EN
  // Illegal-opcode flag, registered alongside the bundle
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      illegal_q <= 1'b0;
    end else begin
      illegal_q <= illegal_d;
    end
  end

  assign bus.IllegalOp = illegal_q;
`endif

  assign bus.RegDst   = ctrl_q.reg_dst;
  assign bus.ALUSrc   = ctrl_q.alu_src;
  assign bus.MemtoReg = ctrl_q.mem_to_reg;
  assign bus.RegWrite = ctrl_q.reg_write;
  assign bus.MemRead  = ctrl_q.mem_read;
  assign bus.MemWrite = ctrl_q.mem_write;
  assign bus.Branch   = ctrl_q.branch;
  assign bus.Jump     = ctrl_q.jump;
  assign bus.ALUOp    = ctrl_q.alu_op;

endmodule

// File: tb/tb_mips_control_unit.sv
// Directed self-checking bench for mips_control_unit.
// Observed vector: {IllegalOp, RegDst, ALUSrc, MemtoReg, RegWrite, MemRead, MemWrite, Branch, Jump, ALUOp}.
// IllegalOp is held at 0 unless ILLEGAL_OPCODE_FLAG_EN is defined.
module tb_mips_control_unit;

  logic clk;
  logic rst;
  int   n_vec;
  int   n_err;

  mips_control_unit_if bus ();

  mips_control_unit dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Gather the DUT outputs into one vector
  function automatic logic [11:0] observed();
    logic ill;
`ifdef ILLEGAL_OPCODE_FLAG_EN
    ill = bus.IllegalOp;
`else
    ill = 1'b0;
`endif
    return {ill, bus.RegDst, bus.ALUSrc, bus.MemtoReg, bus.RegWrite, bus.MemRead,
            bus.MemWrite, bus.Branch, bus.Jump, bus.ALUOp};
  endfunction

  // Hand-written decode table
  function automatic logic [11:0] expected(input logic [5:0] op);
    logic [10:0] e;
    logic        ill;
    ill = 1'b0;
    case (op)
      6'b000000: e = 11'b1_0_0_1_0_0_0_0_010;
      6'b001100: e = 11'b0_1_0_1_0_0_0_0_011;
      6'b001101: e = 11'b0_1_0_1_0_0_0_0_100;
      6'b001001: e = 11'b0_1_0_1_0_0_0_0_000;
      6'b100011: e = 11'b0_1_1_1_1_0_0_0_000;
      6'b101011: e = 11'b0_1_0_0_0_1_0_0_000;
      6'b000100: e = 11'b0_0_0_0_0_0_1_0_001;
      6'b000010: e = 11'b0_0_0_0_0_0_0_1_000;
      default: begin
        e   = '0;
        ill = 1'b1;
      end
    endcase
`ifndef ILLEGAL_OPCODE_FLAG_EN
    ill = 1'b0;
`endif
    return {ill, e};
  endfunction

  task automatic check(input string tag, input logic [11:0] obs, input logic [11:0] exp);
    n_vec++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got %b expected %b", tag, obs, exp);
    end
  endtask

  // Drive opcode at the falling edge, sample 1 time unit after the rising edge
  task automatic apply(input logic [5:0] op);
    @(negedge clk);
    bus.Opcode = op;
    @(posedge clk);
    #1;
    check($sformatf("op_%b", op), observed(), expected(op));
  endtask

  // Per-cycle invariants on the current outputs
  task automatic check_invariants(input logic [5:0] op);
    logic [11:0] v;
    v = observed();
    check($sformatf("nox_%b", op), {11'b0, $isunknown(v)}, 12'b0);
    check($sformatf("rdwr_%b", op), {11'b0, bus.MemRead & bus.MemWrite}, 12'b0);
    check($sformatf("brj_%b", op), {11'b0, bus.Branch & bus.Jump}, 12'b0);
    check($sformatf("m2r_%b", op),
          {11'b0, bus.MemtoReg & ~(bus.MemRead & bus.RegWrite)}, 12'b0);
    check($sformatf("aluop_%b", op), {11'b0, bus.ALUOp > 3'd4}, 12'b0);
  endtask

  localparam logic [5:0] SWEEP [8] = '{6'b000000, 6'b001100, 6'b001101, 6'b001001,
                                       6'b100011, 6'b101011, 6'b000100, 6'b000010};

  initial begin
    n_vec      = 0;
    n_err      = 0;
    rst        = 1'b1;
    bus.Opcode = 6'b000000;

    // Reset clears outputs with no clock edge yet
    #2;
    check("reset_async", observed(), 12'b0);

    // Release and clock once: R-type decode
    @(negedge clk);
    rst = 1'b0;
    @(posedge clk);
    #1;
    check("first_rtype", observed(), 12'b0_1_0_0_1_0_0_0_0_010);

    // Full sweep of listed opcodes
    foreach (SWEEP[i]) apply(SWEEP[i]);

    // Illegal opcodes, then a listed opcode drops the flag
    apply(6'b111111);
    apply(6'b000011);
    apply(6'b100011);

    // Mid-stream reset between edges
    apply(6'b101011);
    rst = 1'b1;
    #1;
    check("midrst_clear", observed(), 12'b0);
    rst = 1'b0;
    #1;
    check("midrst_hold", observed(), 12'b0);
    @(posedge clk);
    #1;
    check("midrst_redecode", observed(), expected(6'b101011));

    // Exhaustive opcode walk with invariants
    for (int k = 0; k < 64; k++) begin
      apply(6'(k));
      check_invariants(6'(k));
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
